// File: rtl/bht_pkg.sv
// ---------------------------------------------------------------------------
// bht_pkg
// Shared definitions for the branch history table (BHT) controller.
//   ST_*       two-bit counter encodings (00 strong-T .. 11 strong-NT)
//   S_INIT/S_RUN  controller FSM encodings
//   bht_train  saturating counter training function
// ---------------------------------------------------------------------------
package bht_pkg;

  localparam logic [1:0] ST_STRONG_T  = 2'b00;
  localparam logic [1:0] ST_WEAK_T    = 2'b01;
  localparam logic [1:0] ST_WEAK_NT   = 2'b10;
  localparam logic [1:0] ST_STRONG_NT = 2'b11;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // A taken branch moves the counter toward strong-T (00), a not-taken branch
  // toward strong-NT (11); both ends saturate.
  function automatic logic [1:0] bht_train(input logic [1:0] state, input logic taken);
    logic [1:0] next;
    next = state;
    if (taken) begin
      if (state != ST_STRONG_T) next = state - 2'd1;
    end else begin
      if (state != ST_STRONG_NT) next = state + 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bht_if.sv
// ---------------------------------------------------------------------------
// bht_if
// Bundles the fetch lookup port, execute update port and status signals of
// the BHT controller.
//   master : pipeline side (drives FLUSH, lookups and updates)
//   slave  : bht_controller side (drives predictions, Ready, Drop_Count)
// Parameters: IDX_W (table index width), DROP_W (drop counter width).
// ---------------------------------------------------------------------------
interface bht_if #(
  parameter int IDX_W  = 6,
  parameter int DROP_W = 8
) ();

  logic              FLUSH;
  logic              Lookup_Valid;
  logic [IDX_W-1:0]  Lookup_Idx;
  logic              Predict_Valid;
  logic              Predict;
  logic [1:0]        Predict_State;
  logic              Update_Valid;
  logic [IDX_W-1:0]  Update_Idx;
  logic              Update_Branch;
  logic              Ready;
  logic [DROP_W-1:0] Drop_Count;

  modport master (
    output FLUSH, Lookup_Valid, Lookup_Idx, Update_Valid, Update_Idx, Update_Branch,
    input  Predict_Valid, Predict, Predict_State, Ready, Drop_Count
  );

  modport slave (
    input  FLUSH, Lookup_Valid, Lookup_Idx, Update_Valid, Update_Idx, Update_Branch,
    output Predict_Valid, Predict, Predict_State, Ready, Drop_Count
  );

endinterface

// File: rtl/bht_counter_next.sv
// ---------------------------------------------------------------------------
// bht_counter_next
// Combinational next-state for one two-bit saturating BHT counter.
//   state  in  2  current counter value
//   taken  in  1  1 = branch resolved taken
//   next   out 2  trained counter value
// ---------------------------------------------------------------------------
module bht_counter_next
  import bht_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  assign next = bht_train(state, taken);

endmodule

// File: rtl/bht_controller.sv
// ---------------------------------------------------------------------------
// bht_controller
// Owns the branch history table: 2^IDX_W two-bit saturating counters held in
// a flop array, with one fetch-side lookup and one execute-side update per
// cycle. After RST or FLUSH the table is rewritten by a one-entry-per-cycle
// sweep; while the sweep runs, updates are dropped and counted.
//
// Ports:
//   CLK   in  clock, all state on posedge
//   RST   in  synchronous active-high reset
//   bus   bht_if.slave : FLUSH, Lookup_*, Update_*, Predict_*, Ready, Drop_Count
//
// Configuration macro: BHT_BYPASS_EN
//   defined   : same-cycle same-index lookup returns the trained (post-update) state
//   undefined : same-cycle same-index lookup returns the pre-update state
// ---------------------------------------------------------------------------
module bht_controller
  import bht_pkg::*;
#(
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         DROP_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  bht_if.slave bus
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [0:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [1:0]        tbl [DEPTH];
  logic              ready;
  logic              upd_en;
  logic [1:0]        upd_next;
  logic [1:0]        rd_state;
  logic              pred_valid_q;
  logic              pred_q;
  logic [1:0]        pred_state_q;
  logic [DROP_W-1:0] drop_q;

  assign ready = (state == S_RUN);

  // An update only lands in RUN and not on the edge that samples FLUSH;
  // every other Update_Valid is a drop.
  assign upd_en = ready & ~bus.FLUSH & bus.Update_Valid;

  bht_counter_next u_upd_next (
    .state (tbl[bus.Update_Idx]),
    .taken (bus.Update_Branch),
    .next  (upd_next)
  );

`ifdef BHT_BYPASS_EN
  assign rd_state = (upd_en && (bus.Update_Idx == bus.Lookup_Idx)) ? upd_next : tbl[bus.Lookup_Idx];
`else
  assign rd_state = tbl[bus.Lookup_Idx];
`endif

  // Sweep sequencing: the edge that writes the last entry moves to RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_INIT;
      ptr   <= '0;
    end else if (bus.FLUSH) begin
      state <= S_INIT;
      ptr   <= '0;
    end else if (state == S_INIT) begin
      ptr <= ptr + 1'b1;
      if (&ptr) state <= S_RUN;
    end
  end

  // Single write port shared by the sweep and training; they never overlap.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if ((state == S_INIT) && !bus.FLUSH) begin
        tbl[ptr] <= INIT_STATE;
      end else if (upd_en) begin
        tbl[bus.Update_Idx] <= upd_next;
      end
    end
  end

  // Prediction holds its last value whenever no lookup is serviced.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pred_valid_q <= 1'b0;
      pred_q       <= 1'b0;
      pred_state_q <= 2'b00;
    end else begin
      pred_valid_q <= bus.Lookup_Valid & ready;
      if (bus.Lookup_Valid && ready) begin
        pred_state_q <= rd_state;
        pred_q       <= ~rd_state[1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_q <= '0;
    end else if (bus.Update_Valid && !upd_en && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.Ready         = ready;
  assign bus.Predict_Valid = pred_valid_q;
  assign bus.Predict       = pred_q;
  assign bus.Predict_State = pred_state_q;
  assign bus.Drop_Count    = drop_q;

endmodule

// File: tb/tb_bht_controller.sv
// ---------------------------------------------------------------------------
// tb_bht_controller
// Self-checking bench for bht_controller (IDX_W=6, INIT_STATE=01, DROP_W=8).
// A reference model holds the table as plain integers, counts sweep cycles
// remaining and the dropped-update total; every cycle's outputs are compared
// against it, with extra fixed-value checks at the interesting points.
// Honours BHT_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bht_controller;

`ifdef BHT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  bht_if #(.IDX_W(6), .DROP_W(8)) bus ();

  bht_controller #(.IDX_W(6), .INIT_STATE(2'b01), .DROP_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int mdl [64];
  int sweepLeft = 64;
  int dropCnt   = 0;
  int expPV     = 0;
  int expPred   = 0;
  int expPS     = 0;

  function automatic int trainModel(input int s, input bit taken);
    if (taken) return (s > 0) ? s - 1 : 0;
    return (s < 3) ? s + 1 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit flush, input bit lv, input int li,
                               input bit uv, input int ui, input bit ub);
    bit rdy;
    bit hit;
    int post;
    RST               = rst;
    bus.FLUSH         = flush;
    bus.Lookup_Valid  = lv;
    bus.Lookup_Idx    = 6'(li);
    bus.Update_Valid  = uv;
    bus.Update_Idx    = 6'(ui);
    bus.Update_Branch = ub;
    @(posedge CLK);
    rdy = (sweepLeft == 0);
    if (rst) begin
      sweepLeft = 64;
      dropCnt   = 0;
      expPV     = 0;
      expPred   = 0;
      expPS     = 0;
    end else begin
      hit  = rdy && !flush && uv;
      post = hit ? trainModel(mdl[ui], ub) : mdl[ui];
      expPV = (lv && rdy) ? 1 : 0;
      if (expPV == 1) begin
        expPS   = (BYPASS && hit && (ui == li)) ? post : mdl[li];
        expPred = (expPS < 2) ? 1 : 0;
      end
      if (flush) begin
        if (uv && dropCnt < 255) dropCnt++;
        sweepLeft = 64;
      end else if (!rdy) begin
        if (uv && dropCnt < 255) dropCnt++;
        sweepLeft--;
        if (sweepLeft == 0) foreach (mdl[i]) mdl[i] = 1;
      end else if (uv) begin
        mdl[ui] = post;
      end
    end
    #1;
    checkOutput("Ready",         32'(bus.Ready),         32'(sweepLeft == 0));
    checkOutput("Drop_Count",    32'(bus.Drop_Count),    32'(dropCnt));
    checkOutput("Predict_Valid", 32'(bus.Predict_Valid), 32'(expPV));
    checkOutput("Predict",       32'(bus.Predict),       32'(expPred));
    checkOutput("Predict_State", 32'(bus.Predict_State), 32'(expPS));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int li;
    int ui;

    // Reset, then sweep with three dropped updates and one lookup in INIT.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_ready", 32'(bus.Ready), 32'd0);
    checkOutput("reset_drop",  32'(bus.Drop_Count), 32'd0);
    checkOutput("reset_pv",    32'(bus.Predict_Valid), 32'd0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, (i == 10), 3, (i == 5 || i == 20 || i == 40), 7, 0);
      if (i == 62) checkOutput("ready_before_64", 32'(bus.Ready), 32'd0);
      if (i == 11) checkOutput("lookup_in_init_pv", 32'(bus.Predict_Valid), 32'd0);
    end
    checkOutput("ready_at_64", 32'(bus.Ready), 32'd1);
    checkOutput("sweep_drops", 32'(bus.Drop_Count), 32'd3);

    // Every entry reads weakly taken after the sweep.
    for (int i = 0; i < 64; i++) applyStimulus(0, 0, 1, i, 0, 0, 0);
    checkOutput("sweep_entry63_state", 32'(bus.Predict_State), 32'd1);
    checkOutput("sweep_entry63_pred",  32'(bus.Predict), 32'd1);

    // Saturation on entry 5.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 5, 0);
    applyStimulus(0, 0, 1, 5, 0, 0, 0);
    checkOutput("sat_nt_state", 32'(bus.Predict_State), 32'd3);
    checkOutput("sat_nt_pred",  32'(bus.Predict), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 5, 1);
    applyStimulus(0, 0, 1, 5, 0, 0, 0);
    checkOutput("sat_t_state", 32'(bus.Predict_State), 32'd0);
    checkOutput("sat_t_pred",  32'(bus.Predict), 32'd1);

    // Same-index lookup and update on entry 9.
    applyStimulus(0, 0, 1, 9, 1, 9, 0);
    checkOutput("collide_state", 32'(bus.Predict_State), BYPASS ? 32'd2 : 32'd1);
    applyStimulus(0, 0, 1, 9, 0, 0, 0);
    checkOutput("collide_after", 32'(bus.Predict_State), 32'd2);

    // Randomised traffic with occasional FLUSH and RST.
    for (int i = 0; i < 500; i++) begin
      li = int'($urandom_range(0, 63));
      ui = ($urandom_range(0, 3) == 0) ? li : int'($urandom_range(0, 63));
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                    1'($urandom), li, 1'($urandom), ui, 1'($urandom));
    end

    // FLUSH mid-run, then RST part-way into the new sweep.
    idle(70);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 2, 0, 0, 0);
    checkOutput("flush_pre_state", 32'(bus.Predict_State), 32'd3);
    applyStimulus(0, 1, 0, 0, 1, 4, 0);
    checkOutput("flush_ready_low", 32'(bus.Ready), 32'd0);
    idle(30);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(63);
    checkOutput("rst_sweep_not_ready", 32'(bus.Ready), 32'd0);
    idle(1);
    checkOutput("rst_sweep_ready", 32'(bus.Ready), 32'd1);
    applyStimulus(0, 0, 1, 2, 0, 0, 0);
    checkOutput("flush_idx2_state", 32'(bus.Predict_State), 32'd1);

    // 300 drops saturate the 8-bit counter.
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 1, 0, 1, 0, 0);
    checkOutput("drop_saturate", 32'(bus.Drop_Count), 32'd255);
    checkOutput("flush_hold_pv", 32'(bus.Predict_Valid), 32'd0);
    idle(64);
    checkOutput("final_ready", 32'(bus.Ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
